// File: rtl/i2c_tx_byte_engine.sv
// I2C master-write byte engine: drains the TX FIFO as START, MSB-first bytes with ACK check, then STOP.
// Every output is registered and is derived from the next state, so the line levels line up with the state register.
module i2c_tx_byte_engine #(
  parameter int DATASIZE = 8,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [DATASIZE-1:0] fifo_rdata_i,
  input  logic                fifo_rempty_i,
  output logic                fifo_rinc_o,
  input  logic                sda_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                busy_o,
  output logic                byte_done_o,
  output logic                ack_err_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, LOAD, BIT, ACK, STOP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          phase_q, phase_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [DATASIZE-1:0] shreg_q, shreg_d;
  logic                ack_smp_q, ack_smp_d;
  logic                scl_q, scl_d;
  logic                sda_q, sda_d;
  logic                rinc_q, rinc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tick;
  logic                timed;
  logic                bit_end;

  assign tick    = (cnt_q == CW'(CLK_DIV - 1));
  assign timed   = (state_q == START) || (state_q == BIT) || (state_q == ACK) || (state_q == STOP);
  assign bit_end = tick && (phase_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ack_smp_d = ack_smp_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (timed) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (enable_i && !fifo_rempty_i) begin
          state_d = START;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_d = LOAD;
      end
      LOAD: begin
        shreg_d   = fifo_rdata_i;
        bit_cnt_d = 3'd7;
        state_d   = BIT;
      end
      BIT: begin
        if (bit_end) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == 3'd0) state_d = ACK;
          else bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ACK: begin
        if (tick && (phase_q == 2'd2)) ack_smp_d = sda_i;
        if (bit_end) begin
          if (ack_smp_q) begin
            err_d   = 1'b1;
            state_d = STOP;
          end else begin
            done_d  = 1'b1;
            state_d = (enable_i && !fifo_rempty_i) ? LOAD : STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end
  end

  // Line levels follow the state/phase being entered, not the one being left.
  always_comb begin
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    rinc_d = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      START: begin
        scl_d = (phase_d != 2'd3);
        sda_d = (phase_d == 2'd0);
      end
      LOAD: begin
        scl_d  = 1'b0;
        sda_d  = sda_q;
        rinc_d = 1'b1;
      end
      BIT: begin
        scl_d = phase_d[1];
        sda_d = shreg_d[DATASIZE-1];
      end
      ACK: begin
        scl_d = phase_d[1];
        sda_d = 1'b1;
      end
      STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = phase_d[1];
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= '0;
      ack_smp_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      rinc_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ack_smp_q <= ack_smp_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      rinc_q    <= rinc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign fifo_rinc_o = rinc_q;
  assign scl_o       = scl_q;
  assign sda_o       = sda_q;
  assign busy_o      = busy_q;
  assign byte_done_o = done_q;
  assign ack_err_o   = err_q;

endmodule

// File: doc/i2c_tx_byte_engine.md
Name: i2c_tx_byte_engine

Overview:
- Read-side consumer of the TX FIFO in the I2C block.
- Pops bytes from the FIFO read port (rdata/rempty/rinc) in the read clock domain.
- Serialises each byte MSB-first onto open-drain SCL/SDA as an I2C master write, with START/STOP framing and ACK check.
- One transaction drains the FIFO: START, then bytes until the FIFO is empty or a NACK, then STOP.

Parameters:
- DATASIZE, 8, FIFO word width; only 8 is supported.
- CLK_DIV, 4, clk_i cycles per quarter SCL period; must be >= 1. One SCL bit = 4*CLK_DIV cycles.

Ports:
- clk_i  input  1  block clock; same as the FIFO read clock.
- rst_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  allows a transaction to start or continue.
- fifo_rdata_i  input  DATASIZE  FIFO head word; valid whenever fifo_rempty_i=0.
- fifo_rempty_i  input  1  FIFO empty flag.
- fifo_rinc_o  output  1  one-cycle pop strobe.
- sda_i  input  1  sampled SDA line, used for ACK.
- scl_o  output  1  SCL level; 1 = released.
- sda_o  output  1  SDA level; 1 = released.
- busy_o  output  1  transaction in progress.
- byte_done_o  output  1  one-cycle pulse after an ACKed byte.
- ack_err_o  output  1  sticky NACK flag.

Behaviour:
- Clock and reset are fixed: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values: scl_o=1, sda_o=1, fifo_rinc_o=0, busy_o=0, byte_done_o=0, ack_err_o=0, state=IDLE, counters=0. All outputs are registered.
- Reset mid-transaction forces the idle levels immediately. A byte already popped is lost; the FIFO is not rewound.
- Tick generator:
  - cnt counts 0..CLK_DIV-1; tick is asserted when cnt=CLK_DIV-1.
  - phase (0..3) advances on each tick.
  - cnt and phase are held at 0 in IDLE and LOAD, and are cleared on every state change.
- States and transitions:
  - IDLE: busy_o=0, scl=1, sda=1. If enable_i=1 and fifo_rempty_i=0, go to START next cycle and clear ack_err_o.
  - START (4 ticks): phase0 scl=1/sda=1; phase1-2 scl=1/sda=0; phase3 scl=0/sda=0. Tick at the end of phase3 -> LOAD.
  - LOAD (1 cycle): shreg<=fifo_rdata_i, fifo_rinc_o=1 for this cycle only, bit_cnt<=7, scl=0, sda held. Next state is BIT. LOAD is only entered with the FIFO non-empty.
  - BIT (4 ticks per bit): phase0-1 scl=0; phase2-3 scl=1. sda=shreg[7] for the whole bit, so SDA changes only while SCL is low. At the end of phase3: shift left; if bit_cnt=0 go to ACK, else decrement bit_cnt.
  - ACK (4 ticks): sda=1 (released); SCL waveform as in BIT. sda_i is sampled on the tick ending phase2.
    - Sampled 1 (NACK): set ack_err_o, go to STOP.
    - Sampled 0: pulse byte_done_o. If enable_i=1 and fifo_rempty_i=0, go to LOAD (repeated byte, no new START); otherwise go to STOP.
  - STOP (4 ticks): phase0 scl=0/sda=0; phase1 scl=1/sda=0; phase2-3 scl=1/sda=1. Then go to IDLE.
- Deasserting enable_i mid-byte does not abort: the current byte and its ACK complete, then STOP.
- A FIFO write during ACK is picked up if fifo_rempty_i=0 at the decision cycle.
- ack_err_o stays set until the next START or reset.
- Latency for one byte with CLK_DIV=4: START 16 + LOAD 1 + 8 bits x16 + ACK 16 + STOP 16 = 177 cycles, with busy_o high throughout.
- At most one pop per byte; fifo_rinc_o is never asserted while fifo_rempty_i=1.

Test Plan:
- Reset with the FIFO empty, enable_i=1 -> scl_o=sda_o=1, busy_o=0, no fifo_rinc_o pulse for 200 cycles.
- CLK_DIV=4, FIFO holds 0xA5, sda_i=0 in ACK -> SDA during the SCL-high phases reads 1,0,1,0,0,1,0,1. Exactly one fifo_rinc_o pulse, one byte_done_o pulse, busy_o high for 177 cycles, then the STOP pattern.
- FIFO holds 0x3C,0xFF,0x00, ACK each -> one START, three LOADs without an intervening STOP, 3 pops, 3 byte_done_o pulses, one STOP, FIFO empty.
- FIFO holds 0x12,0x34, sda_i=1 on the first ACK -> ack_err_o=1, STOP right after the first byte, 0x34 left in the FIFO. ack_err_o clears on the next START.
- Drop enable_i during bit 3 of 0x81 with 2 bytes queued -> byte 0x81 and its ACK complete, then STOP; one pop only.
- Assert rst_i during bit 5 -> scl_o=sda_o=1 and busy_o=0 asynchronously. After release, a new transaction starts cleanly with the next FIFO byte.
